// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD -> excess-3 word sequencer.
package bcd_xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/xs3_digit_conv.sv
// Single-digit BCD -> excess-3 converter (combinational).
// Non-BCD digits (>9) produce 4'h0 and raise invalid.
module xs3_digit_conv
    import bcd_xs3_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] xs3,
    output logic       invalid
);

    // Add the excess-3 offset, or zero the nibble for an illegal digit
    always_comb begin
        invalid = (d > BCD_MAX);
        xs3     = invalid ? 4'h0 : (d + XS3_OFFSET);
    end

endmodule

// File: rtl/bcd_xs3_word_seq.sv
// Word sequencer: accepts a packed BCD word, converts one digit per clock
// (least-significant first) through one shared converter, and returns the
// excess-3 word plus a sticky non-BCD flag over a valid/ready handshake.
module bcd_xs3_word_seq
    import bcd_xs3_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_xs3,
    output logic                out_err,
    output logic                busy
);

    localparam int unsigned     IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned     W        = 4 * DIGITS;
    localparam logic [IW-1:0]   LAST_IDX = IW'(DIGITS - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_shift;
    logic [W-1:0]    r_xs3;
    logic            r_err;
    logic            r_out_valid;

    logic            w_in_ready;
    logic            w_busy;
    logic            w_accept;
    logic            w_release;
    logic            w_last;
    logic [3:0]      w_dig_xs3;
    logic            w_dig_err;

    // The current digit is always the low nibble of the shift register
    xs3_digit_conv u_conv (
        .d       (r_shift[3:0]),
        .xs3     (w_dig_xs3),
        .invalid (w_dig_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = CONV;
            CONV:    if (w_last)    w_next_state = DONE;
            DONE:    if (w_release) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Handshake and status decode, from registered state only
    always_comb begin
        w_in_ready = (r_state == IDLE);
        w_busy     = (r_state != IDLE);
        w_last     = (r_idx == LAST_IDX);
        w_accept   = in_valid && w_in_ready;
        w_release  = (r_state == DONE) && r_out_valid && out_ready;
    end

    // Datapath: capture, per-digit conversion, result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_shift     <= '0;
            r_xs3       <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift <= in_bcd;
                        r_xs3   <= '0;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                CONV: begin
                    r_xs3[{r_idx, 2'b00} +: 4] <= w_dig_xs3;
                    if (w_dig_err) begin
                        r_err <= 1'b1;
                    end
                    r_shift <= r_shift >> 4;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (w_release) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign out_xs3   = r_xs3;
    assign out_err   = r_err;

endmodule
